// File: rtl/gauss_filter_pkg.sv
// Shared types for the 3x3 Gaussian/edge filter: corner codes, sequencer states, corner decode.
package gauss_filter_pkg;

   localparam int unsigned CT_W = 4;

   typedef enum logic [CT_W-1:0] {
      CT_NONE = 4'd0,
      CT_BR   = 4'd1,
      CT_BL   = 4'd2,
      CT_RCOL = 4'd3,
      CT_LCOL = 4'd4,
      CT_TR   = 4'd5,
      CT_TL   = 4'd6,
      CT_FULL = 4'd8
   } corner_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Coefficient select from the centre's position flags; first/last row interiors use the full kernel.
   function automatic corner_t corner_of(input logic top, input logic bot,
                                         input logic lft, input logic rgt);
      corner_t ct;
      ct = CT_FULL;
      if (top && lft)      ct = CT_TL;
      else if (top && rgt) ct = CT_TR;
      else if (bot && lft) ct = CT_BL;
      else if (bot && rgt) ct = CT_BR;
      else if (lft)        ct = CT_LCOL;
      else if (rgt)        ct = CT_RCOL;
      return ct;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay: o_data_c is the sample written DEPTH enabled steps ago (circular RAM + pointer).
module line_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 640
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_ptr;

   // Storage: overwrite the oldest entry each step (no reset, refilled by priming).
   always_ff @(posedge clk) begin
      if (i_en) r_mem[r_ptr] <= i_data;
   end

   // Write/read pointer wrapping at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_ptr <= '0;
      else if (i_en) begin
         if (r_ptr == PTR_W'(DEPTH - 1))   r_ptr <= '0;
         else                              r_ptr <= r_ptr + PTR_W'(1);
      end
   end

   assign o_data_c = r_mem[r_ptr];

endmodule

// File: rtl/gauss_window_ctrl.sv
// Raster-scan 3x3 window sequencer feeding computing_block and registering its result.
module gauss_window_ctrl
   import gauss_filter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] win_l0_d0,
   output logic [DATA_WIDTH-1:0] win_l0_d1,
   output logic [DATA_WIDTH-1:0] win_l0_d2,
   output logic [DATA_WIDTH-1:0] win_l1_d0,
   output logic [DATA_WIDTH-1:0] win_l1_d1,
   output logic [DATA_WIDTH-1:0] win_l1_d2,
   output logic [DATA_WIDTH-1:0] win_l2_d0,
   output logic [DATA_WIDTH-1:0] win_l2_d1,
   output logic [DATA_WIDTH-1:0] win_l2_d2,
   output logic [CT_W-1:0]       corner_type,
   input  logic [DATA_WIDTH-1:0] filt_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned NPIX  = IMG_W * IMG_H;
   localparam int unsigned CNT_W = $clog2(NPIX);
   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H + 1);

   state_t                          r_state, w_next;
   logic                            r_in_ready, r_busy, w_in_ready_n, w_busy_n;
   logic [CNT_W-1:0]                r_cnt;
   logic [COL_W-1:0]                r_ocol;
   logic [ROW_W-1:0]                r_orow;
   logic                            w_acc, w_flush_step, w_step, w_win;
   logic                            w_cnt_is_w, w_cnt_last;
   logic [DATA_WIDTH-1:0]           w_pix, w_lb0, w_lb1;
   logic [2:0][DATA_WIDTH-1:0]      r_col_a, r_col_b, w_col_n;
   logic [2:0][2:0][DATA_WIDTH-1:0] r_tap, w_tap_n;
   logic                            w_top, w_bot, w_lft, w_rgt;
   corner_t                         r_ct;
   logic                            r_win_vld, r_out_valid, r_done_d1, r_frame_done;
   logic [DATA_WIDTH-1:0]           r_out_data;

   assign w_acc        = in_valid & r_in_ready;
   assign w_flush_step = (r_state == ST_FLUSH);
   assign w_step       = w_acc | w_flush_step;
   assign w_win        = (w_acc & (r_state == ST_RUN)) | w_flush_step;
   assign w_pix        = w_flush_step ? '0 : in_data;
   assign w_cnt_is_w   = (r_cnt == CNT_W'(IMG_W));
   assign w_cnt_last   = (r_cnt == CNT_W'(NPIX - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next state and next-cycle handshake/busy levels.
   always_comb begin
      w_next       = r_state;
      w_in_ready_n = 1'b0;
      w_busy_n     = 1'b1;
      unique case (r_state)
         ST_IDLE:  if (start) w_next = ST_PRIME;
         ST_PRIME: if (w_acc && w_cnt_is_w) w_next = ST_RUN;
         ST_RUN:   if (w_acc && w_cnt_last) w_next = ST_FLUSH;
         ST_FLUSH: if (w_cnt_is_w) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      w_in_ready_n = (w_next == ST_PRIME) || (w_next == ST_RUN);
      w_busy_n     = (w_next != ST_IDLE);
   end

   // Registered in_ready/busy track the state register exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_in_ready <= w_in_ready_n;
         r_busy     <= w_busy_n;
      end
   end

   // Input index during PRIME/RUN, reused as flush step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_cnt <= '0;
      else if (r_state == ST_IDLE)                     r_cnt <= '0;
      else if (r_state == ST_RUN && w_next == ST_FLUSH) r_cnt <= '0;
      else if (w_step)                                 r_cnt <= r_cnt + CNT_W'(1);
   end

   // Output centre row/column, advanced once per completed window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ocol <= '0;
         r_orow <= '0;
      end else if (r_state == ST_IDLE) begin
         r_ocol <= '0;
         r_orow <= '0;
      end else if (w_win) begin
         if (r_ocol == COL_W'(IMG_W - 1)) begin
            r_ocol <= '0;
            r_orow <= r_orow + ROW_W'(1);
         end else begin
            r_ocol <= r_ocol + COL_W'(1);
         end
      end
   end

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
      .clk(clk), .rst_n(rst_n), .i_en(w_step), .i_data(w_pix), .o_data_c(w_lb0)
   );

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .i_en(w_step), .i_data(w_lb0), .o_data_c(w_lb1)
   );

   // Incoming column c+1: row r-1 from the second line buffer, row r+1 is the live pixel.
   assign w_col_n[0] = w_lb1;
   assign w_col_n[1] = w_lb0;
   assign w_col_n[2] = w_pix;

   // Raw columns c-1 and c, shifted every step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_a <= '0;
         r_col_b <= '0;
      end else if (w_step) begin
         r_col_a <= r_col_b;
         r_col_b <= w_col_n;
      end
   end

   assign w_top = (r_orow == ROW_W'(0));
   assign w_bot = (r_orow == ROW_W'(IMG_H - 1));
   assign w_lft = (r_ocol == COL_W'(0));
   assign w_rgt = (r_ocol == COL_W'(IMG_W - 1));

   // Assemble taps, zeroing anything outside the image (also kills horizontal wrap).
   always_comb begin
      w_tap_n = '0;
      for (int l = 0; l < 3; l++) begin
         for (int d = 0; d < 3; d++) begin
            if (d == 0)      w_tap_n[l][d] = r_col_a[l];
            else if (d == 1) w_tap_n[l][d] = r_col_b[l];
            else             w_tap_n[l][d] = w_col_n[l];
            if ((l == 0 && w_top) || (l == 2 && w_bot) ||
                (d == 0 && w_lft) || (d == 2 && w_rgt))
               w_tap_n[l][d] = '0;
         end
      end
   end

   // Window taps and corner code registered on completion; code clears when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap     <= '0;
         r_ct      <= CT_NONE;
         r_win_vld <= 1'b0;
      end else begin
         r_win_vld <= w_win;
         if (w_win) begin
            r_tap <= w_tap_n;
            r_ct  <= corner_of(w_top, w_bot, w_lft, w_rgt);
         end else begin
            r_ct  <= CT_NONE;
         end
      end
   end

   // Output stage and frame_done aligned one cycle after the final output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_done_d1    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_out_valid  <= r_win_vld;
         if (r_win_vld) r_out_data <= filt_data;
         r_done_d1    <= (r_state == ST_DONE);
         r_frame_done <= r_done_d1;
      end
   end

   assign in_ready    = r_in_ready;
   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign frame_done  = r_frame_done;
   assign corner_type = r_ct;
   assign win_l0_d0   = r_tap[0][0];
   assign win_l0_d1   = r_tap[0][1];
   assign win_l0_d2   = r_tap[0][2];
   assign win_l1_d0   = r_tap[1][0];
   assign win_l1_d1   = r_tap[1][1];
   assign win_l1_d2   = r_tap[1][2];
   assign win_l2_d0   = r_tap[2][0];
   assign win_l2_d1   = r_tap[2][1];
   assign win_l2_d2   = r_tap[2][2];

endmodule

// File: doc/gauss_window_ctrl.md
# gauss_window_ctrl

Raster-scan sequencer for the 3x3 edge/Gaussian filter datapath. Accepts a frame as a pixel stream, keeps the two previous lines in line buffers and builds the 3x3 window. It drives the nine window taps and the `corner_type` code into `computing_block`, then registers the block's result as an output pixel stream. One output pixel per input pixel, plus a flush tail at end of frame.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `IMG_W`, 640, frame width in pixels, ≥ 2.
- `IMG_H`, 480, frame height in lines, ≥ 2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: input accepted when `in_valid & in_ready`.
- `in_data` in DATA_WIDTH: input pixel, raster order.
- `win_l{0,1,2}_d{0,1,2}` out DATA_WIDTH each: window taps to `computing_block`.
  - Line 0 is row r-1; line 2 is row r+1.
  - d0 is column c-1; d2 is column c+1.
- `corner_type` out 4: coefficient select to `computing_block`.
- `filt_data` in DATA_WIDTH: `computing_block.data_out`, combinational return.
- `out_valid` out 1: output pixel valid. No backpressure.
- `out_data` out DATA_WIDTH: filtered pixel.
- `busy` out 1: high outside IDLE.
- `frame_done` out 1: one-cycle pulse after the last output.

## Operation
- **Centre indexing:** output centre index p = r·IMG_W + c. Window for p is complete when input index p+IMG_W+1 is accepted. Indices ≥ IMG_W·IMG_H are virtual.
- **FSM states:**
  - IDLE: `in_ready`=0. On `start`, go to PRIME.
  - PRIME: `in_ready`=1. Accept the first IMG_W+1 pixels; no output. Go to RUN after the last of these is accepted.
  - RUN: `in_ready`=1. Each accepted pixel completes one window. Go to FLUSH after input index IMG_W·IMG_H-1 is accepted.
  - FLUSH: `in_ready`=0. Complete one window per clock for IMG_W+1 clocks, with virtual pixels equal to 0. Then go to DONE.
  - DONE: one cycle; pulse `frame_done`, then go to IDLE.
- **Window taps:** any tap outside the image (row -1/IMG_H, column -1/IMG_W) is driven 0. Horizontal wrap from the adjacent line must never appear on a tap.
- **`corner_type` by centre (r,c):**
  - 6 at (0,0); 5 at (0,IMG_W-1).
  - 2 at (IMG_H-1,0); 1 at (IMG_H-1,IMG_W-1).
  - 4 at column 0 interior rows; 3 at column IMG_W-1 interior rows.
  - 8 everywhere else, including first/last-row interiors.
  - 0 on any cycle where no window completes.
- **Counters:** input index counter; output row/col counters that wrap col IMG_W-1→0 and row++.
- **Reset mid-frame:** everything returns to IDLE. Line buffer contents are don't-care because PRIME refills them.
- **`start` while busy:** ignored.

## Timing
- Taps and `corner_type` are valid in the cycle after the completing acceptance (registered window). `filt_data` is sampled that same cycle.
- `out_data` is registered one further cycle: latency 2 clocks from the completing input acceptance to `out_valid`.
- `in_valid` gaps stall the window. `out_valid` simply drops; there are no bubbles in ordering.
- Reset values:
  - `in_ready`, `out_valid`, `busy`, `frame_done` = 0.
  - `out_data`, all taps = 0.
  - `corner_type` = 0.
- `frame_done` asserts the cycle after the final `out_valid`.
- Total outputs per frame = IMG_W·IMG_H exactly.

## Structure
- Shared package `gauss_filter_pkg`:
  - Corner codes CT_NONE=0, CT_BR=1, CT_BL=2, CT_RCOL=3, CT_LCOL=4, CT_TR=5, CT_TL=6, CT_FULL=8.
  - FSM state encoding.
- Sub-module `line_buffer`: IMG_W-deep, DATA_WIDTH-wide delay line with an enable. Two instances, chained; enable = acceptance or flush step.
- The window registers, counters and FSM live in the top.

## Test plan
- **Corner sequence:** IMG_W=4, IMG_H=3, pixels 0..11, continuous `in_valid` → 12 outputs with `corner_type` 6,8,8,5,4,8,8,3,2,8,8,1. `in_ready` low for exactly 5 flush cycles.
- **Tap check:** same frame, centre (1,1) → taps l0=0,1,2 / l1=4,5,6 / l2=8,9,10. Centre (0,3) → l0 all 0, l1=2,3,0, l2=6,7,0.
- **End-to-end:** IMG_W=4, IMG_H=3, constant 16 frame with real `computing_block` → `out_data`=3 at (0,0), 0 at every CT_FULL position. `frame_done` pulses once.
- **Input gaps:** random `in_valid` gaps on the ramp frame → identical output sequence to the continuous run. `out_valid` count = 12.
- **Reset mid-frame:** `rst_n` low during RUN after pixel 7 → all outputs at reset values. A following full frame produces the correct 12-output sequence.
- **Busy start:** `start` pulsed during PRIME/RUN → no effect; a single `frame_done` for the frame.
